mult_div_unit: RTL and testbench

Multi-cycle signed multiply/divide unit that answers the control unit's `mult`/`div` start requests. It sits in the datapath beside the ALU, takes operands from the A/B registers, runs a 32-iteration shift-based algorithm, and returns a one-cycle completion strobe plus a divide-by-zero flag. The control FSM waits on these before writing the HI/LO registers.

---
 rtl/mult_div_unit.sv | 182 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Signed 32x32 multiply (radix-2 Booth) and signed restoring divide, Hi/Lo result registers.
// Latency: 33 cycles from start edge to End strobe; divide-by-zero strobes after 1 cycle.
// No backpressure: starts are sampled only in IDLE, ignored (not queued) while Busy.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             MultStart,
  input  logic             DivStart,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             MultEnd,
  output logic             DivEnd,
  output logic             DivZero,
  output logic             Busy
);

  localparam int              CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST_ITER = CW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  // Booth: sign-extended accumulator (extra bit keeps -2^31 multiplicand exact).
  // Divide: partial remainder in the low WIDTH bits.
  logic [WIDTH:0]   r_acc;
  // Booth: multiplier being shifted out. Divide: dividend shifting out, quotient shifting in.
  logic [WIDTH-1:0] r_q;
  logic             r_q1;
  // Booth: sign-extended multiplicand. Divide: zero-extended divisor magnitude.
  logic [WIDTH:0]   r_m;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_mult_end;
  logic             r_div_end;
  logic             r_div_zero;
  logic             r_busy;

  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_booth_sum;
  logic [2*WIDTH+1:0] w_booth_sh;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_rem_sub;
  logic               w_rem_ge;
  logic [WIDTH:0]     w_rem_next;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_abs_a = A[WIDTH-1] ? -A : A;
  assign w_abs_b = B[WIDTH-1] ? -B : B;

  // Booth recode of {q0, q-1}: 01 adds the multiplicand, 10 subtracts it.
  always_comb begin
    w_booth_sum = r_acc;
    case ({r_q[0], r_q1})
      2'b01:   w_booth_sum = r_acc + r_m;
      2'b10:   w_booth_sum = r_acc - r_m;
      default: w_booth_sum = r_acc;
    endcase
  end

  // Arithmetic shift right of {acc, q, q-1}; the old q-1 falls off the end.
  assign w_booth_sh = {w_booth_sum[WIDTH], w_booth_sum, r_q};

  // Restoring step: shift the next dividend bit into the remainder, subtract if it fits.
  assign w_rem_sh   = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_rem_ge   = (w_rem_sh >= r_m);
  assign w_rem_sub  = w_rem_sh - r_m;
  assign w_rem_next = w_rem_ge ? w_rem_sub : w_rem_sh;

  // Sign fix-up: quotient negative when operand signs differ, remainder follows the dividend.
  // Negating 0x80000000 wraps to itself, which gives the required overflow result.
  assign w_quo_fix = r_neg_q ? -r_q : r_q;
  assign w_rem_fix = r_neg_r ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];

  // Control FSM, datapath iteration and registered result/strobe outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_q        <= '0;
      r_q1       <= 1'b0;
      r_m        <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dz       <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_mult_end <= 1'b0;
      r_div_end  <= 1'b0;
      r_div_zero <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_mult_end <= 1'b0;
      r_div_end  <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (MultStart) begin
            r_acc   <= '0;
            r_q     <= B;
            r_q1    <= 1'b0;
            r_m     <= {A[WIDTH-1], A};
            r_dz    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_MULT;
          end else if (DivStart) begin
            r_acc   <= '0;
            r_q     <= w_abs_a;
            r_q1    <= 1'b0;
            r_m     <= {1'b0, w_abs_b};
            r_neg_q <= A[WIDTH-1] ^ B[WIDTH-1];
            r_neg_r <= A[WIDTH-1];
            // A zero divisor skips the iteration loop; the next edge drives the strobes.
            r_dz    <= (B == '0);
            r_busy  <= 1'b1;
            r_state <= S_DIV;
          end
        end
        S_MULT: begin
          if (r_cnt == LAST_ITER) begin
            r_hi       <= r_acc[WIDTH-1:0];
            r_lo       <= r_q;
            r_mult_end <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            {r_acc, r_q, r_q1} <= w_booth_sh;
            r_cnt              <= r_cnt + CW'(1);
          end
        end
        S_DIV: begin
          if (r_dz) begin
            r_div_end  <= 1'b1;
            r_div_zero <= 1'b1;
            r_state    <= S_DONE;
          end else if (r_cnt == LAST_ITER) begin
            r_hi      <= w_rem_fix;
            r_lo      <= w_quo_fix;
            r_div_end <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_acc <= w_rem_next;
            r_q   <= {r_q[WIDTH-2:0], w_rem_ge};
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          r_dz    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign Hi      = r_hi;
  assign Lo      = r_lo;
  assign MultEnd = r_mult_end;
  assign DivEnd  = r_div_end;
  assign DivZero = r_div_zero;
  assign Busy    = r_busy;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: signed multiply/divide vectors, div-by-zero, start handling, reset abort.
// Latency: checks 33-cycle normal and 1-cycle divide-by-zero strobe timing.
// No backpressure: starts are pulsed for one edge; outputs sampled on the falling edge.
module tb_mult_div_unit;

  logic        clock;
  logic        reset;
  logic        MultStart;
  logic        DivStart;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        MultEnd;
  logic        DivEnd;
  logic        DivZero;
  logic        Busy;

  int n_cmp;
  int n_bad;
  logic [31:0] prev_hi;
  logic [31:0] prev_lo;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .MultStart (MultStart),
    .DivStart  (DivStart),
    .A         (A),
    .B         (B),
    .Hi        (Hi),
    .Lo        (Lo),
    .MultEnd   (MultEnd),
    .DivEnd    (DivEnd),
    .DivZero   (DivZero),
    .Busy      (Busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse a start for one edge, wait for the End strobe, check timing and results.
  task automatic run_op(input string tag, input bit do_mult, input bit do_div,
                        input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                        input bit exp_me, input bit exp_dz,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input bit disturb);
    int lat;
    lat = -1;
    @(negedge clock);
    A = a;
    B = b;
    MultStart = do_mult;
    DivStart = do_div;
    @(posedge clock);
    #1;
    MultStart = 1'b0;
    DivStart = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (MultEnd || DivEnd) begin
        lat = k;
        break;
      end
      if (k == 2) begin
        check_val({tag, "/busy"}, 64'(Busy), 64'd1);
        check_val({tag, "/hold"}, {Hi, Lo}, {prev_hi, prev_lo});
      end
      if (disturb && k == 10) begin
        A = ~a;
        DivStart = 1'b1;
      end
      if (disturb && k == 11) DivStart = 1'b0;
    end
    check_val({tag, "/lat"}, 64'(lat), 64'(exp_lat));
    check_val({tag, "/ends"}, {61'd0, MultEnd, DivEnd, DivZero}, {61'd0, exp_me, ~exp_me, exp_dz});
    check_val({tag, "/hilo"}, {Hi, Lo}, {exp_hi, exp_lo});
    @(negedge clock);
    check_val({tag, "/after"}, {60'd0, MultEnd, DivEnd, DivZero, Busy}, 64'd0);
    prev_hi = exp_hi;
    prev_lo = exp_lo;
  endtask

  initial begin
    bit seen;
    n_cmp = 0;
    n_bad = 0;
    prev_hi = '0;
    prev_lo = '0;
    reset = 1'b0;
    MultStart = 1'b0;
    DivStart = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_val("reset/hilo", {Hi, Lo}, 64'd0);
    check_val("reset/flags", {60'd0, MultEnd, DivEnd, DivZero, Busy}, 64'd0);
    reset = 1'b1;

    // multiply
    run_op("mul7xm3",  1, 0, 32'd7,        32'hFFFFFFFD, 33, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
    run_op("mulminsq", 1, 0, 32'h80000000, 32'h80000000, 33, 1, 0, 32'h40000000, 32'h00000000, 0);
    run_op("mulmaxsq", 1, 0, 32'h7FFFFFFF, 32'h7FFFFFFF, 33, 1, 0, 32'h3FFFFFFF, 32'h00000001, 0);
    // divide
    run_op("divm7d2",  0, 1, 32'hFFFFFFF9, 32'd2,        33, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run_op("div7dm2",  0, 1, 32'd7,        32'hFFFFFFFE, 33, 0, 0, 32'h00000001, 32'hFFFFFFFD, 0);
    run_op("div100d7", 0, 1, 32'd100,      32'd7,        33, 0, 0, 32'h00000002, 32'h0000000E, 0);
    run_op("divm100m7",0, 1, 32'hFFFFFF9C, 32'hFFFFFFF9, 33, 0, 0, 32'hFFFFFFFE, 32'h0000000E, 0);
    run_op("divovf",   0, 1, 32'h80000000, 32'hFFFFFFFF, 33, 0, 0, 32'h00000000, 32'h80000000, 0);
    // divide by zero keeps the previous result
    run_op("divzero",  0, 1, 32'd5,        32'd0,         1, 0, 1, 32'h00000000, 32'h80000000, 0);
    // both starts: multiply wins
    run_op("bothstart",1, 1, 32'd6,        32'd5,        33, 1, 0, 32'h00000000, 32'h0000001E, 0);
    // A changed and DivStart pulsed mid-multiply
    run_op("disturb",  1, 0, 32'h00001234, 32'h00000010, 33, 1, 0, 32'h00000000, 32'h00012340, 1);

    // reset during iteration 15 of a divide
    @(negedge clock);
    A = 32'd1000;
    B = 32'd3;
    DivStart = 1'b1;
    @(posedge clock);
    #1;
    DivStart = 1'b0;
    for (int k = 0; k < 15; k++) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_val("abort/hilo", {Hi, Lo}, 64'd0);
    check_val("abort/flags", {60'd0, MultEnd, DivEnd, DivZero, Busy}, 64'd0);
    reset = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (DivEnd || Busy) seen = 1'b1;
    end
    check_val("abort/noend", 64'(seen), 64'd0);
    prev_hi = '0;
    prev_lo = '0;
    run_op("mul3x4",   1, 0, 32'd3,        32'd4,        33, 1, 0, 32'h00000000, 32'h0000000C, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
